// File: rtl/nibble_serial_cla_subtractor.sv
// Nibble-serial subtractor: D = A - B - Bin, one 4-bit borrow-lookahead stage per clock.
// Optional signed-overflow output is enabled by defining SUBTRACTOR_OVF_EN.
module nibble_serial_cla_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] D,
    output logic                 Bout,
    output logic                 Zero
`ifdef SUBTRACTOR_OVF_EN
    ,
    output logic                 Ovf
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    d_r;
    logic [W-1:0]    d_next_s;
    logic            borrow_r;
    logic            bout_r;
    logic            zero_r;
    logic [IW-1:0]   idx_r;
    logic [3:0]      nib_a_s;
    logic [3:0]      nib_b_s;
    logic [3:0]      nib_d_s;
    logic [4:0]      borrows_s;
    logic            last_s;
`ifdef SUBTRACTOR_OVF_EN
    logic            ovf_r;
`endif

    // Two-level borrow lookahead: returns {b4,b3,b2,b1,b0} with b0 = borrow-in.
    function automatic logic [4:0] borrow_chain(input logic [3:0] a, input logic [3:0] b,
                                                input logic bi);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] bo;
        g     = ~a & b;
        p     = ~(a ^ b);
        bo[0] = bi;
        bo[1] = g[0] | (p[0] & bi);
        bo[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
        bo[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
        bo[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bi);
        return bo;
    endfunction

    // Current nibble slice, its difference and the result with that nibble merged in.
    always_comb begin
        nib_a_s   = a_r[{idx_r, 2'b00} +: 4];
        nib_b_s   = b_r[{idx_r, 2'b00} +: 4];
        borrows_s = borrow_chain(nib_a_s, nib_b_s, borrow_r);
        nib_d_s   = nib_a_s ^ nib_b_s ^ borrows_s[3:0];
        d_next_s  = d_r;
        d_next_s[{idx_r, 2'b00} +: 4] = nib_d_s;
        last_s    = (idx_r == IW'(NIBBLES - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, per-nibble result write and final flag registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= {W{1'b0}};
            b_r      <= {W{1'b0}};
            d_r      <= {W{1'b0}};
            borrow_r <= 1'b0;
            bout_r   <= 1'b0;
            zero_r   <= 1'b0;
            idx_r    <= {IW{1'b0}};
`ifdef SUBTRACTOR_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= A;
                        b_r      <= B;
                        borrow_r <= Bin;
                        idx_r    <= {IW{1'b0}};
                    end
                end
                RUN: begin
                    d_r      <= d_next_s;
                    borrow_r <= borrows_s[4];
                    if (last_s) begin
                        bout_r <= borrows_s[4];
                        zero_r <= (d_next_s == {W{1'b0}});
`ifdef SUBTRACTOR_OVF_EN
                        ovf_r  <= (a_r[W-1] ^ b_r[W-1]) & (a_r[W-1] ^ d_next_s[W-1]);
`endif
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshakes come from registered state only; reset masks them.
    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = (state_r == DONE) && !rst;
    assign D         = d_r;
    assign Bout      = bout_r;
    assign Zero      = zero_r;
`ifdef SUBTRACTOR_OVF_EN
    assign Ovf       = ovf_r;
`endif

endmodule
